ex_mem_pipe_stage: RTL and testbench

Parametrised EX/MEM pipeline stage for the custom pipelined processor, the successor to the fixed-width unconditional EX/MEM register. It carries the EX-stage result bundle (ALU result, store data, destination, WB/MEM/float control) to the MEM stage. Beats move under a valid/ready handshake with a 2-entry skid buffer, so back-pressure costs no throughput. It also provides synchronous flush, control-bit squashing on bubbles, and a saturating stall counter for performance monitoring.

---
 rtl/ex_mem_pipe_stage_if.sv | 54 +++++
 rtl/ex_mem_pipe_stage.sv | 131 +++++++++++++
 tb/tb_ex_mem_pipe_stage.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_pipe_stage_if.sv
// ex_mem_pipe_stage_if
//   EX -> MEM handshake bundle for the EX/MEM pipeline stage.
//   Input side : in_valid/in_ready plus the EX result fields (*_in).
//   Output side: out_valid/out_ready plus the registered copies (*_out).
//   slave  : stage view (consumes *_in, drives *_out and in_ready).
//   master : environment view (drives *_in and out_ready).
interface ex_mem_pipe_stage_if #(
  parameter int RES_W   = 64,
  parameter int RT_W    = 32,
  parameter int DEST_W  = 5,
  parameter int WB_W    = 4,
  parameter int MEM_W   = 3,
  parameter int FLOAT_W = 2
);
  logic               in_valid;
  logic               in_ready;
  logic [WB_W-1:0]    wb_in;
  logic [MEM_W-1:0]   mem_in;
  logic [FLOAT_W-1:0] float_in;
  logic [RES_W-1:0]   alu_res_in;
  logic [RT_W-1:0]    rt_data_in;
  logic [DEST_W-1:0]  dest_in;
  logic               alu_mem_read_in;
  logic               alu_mem_write_in;
  logic               alu_RegWrite_in;

  logic               out_valid;
  logic               out_ready;
  logic [WB_W-1:0]    wb_out;
  logic [MEM_W-1:0]   mem_out;
  logic [FLOAT_W-1:0] float_out;
  logic [RES_W-1:0]   alu_res_out;
  logic [RT_W-1:0]    rt_data_out;
  logic [DEST_W-1:0]  dest_out;
  logic               alu_mem_read_out;
  logic               alu_mem_write_out;
  logic               alu_RegWrite_out;

  modport slave (
    input  in_valid, wb_in, mem_in, float_in, alu_res_in, rt_data_in, dest_in,
           alu_mem_read_in, alu_mem_write_in, alu_RegWrite_in, out_ready,
    output in_ready, out_valid, wb_out, mem_out, float_out, alu_res_out,
           rt_data_out, dest_out, alu_mem_read_out, alu_mem_write_out,
           alu_RegWrite_out
  );

  modport master (
    output in_valid, wb_in, mem_in, float_in, alu_res_in, rt_data_in, dest_in,
           alu_mem_read_in, alu_mem_write_in, alu_RegWrite_in, out_ready,
    input  in_ready, out_valid, wb_out, mem_out, float_out, alu_res_out,
           rt_data_out, dest_out, alu_mem_read_out, alu_mem_write_out,
           alu_RegWrite_out
  );
endinterface

// File: rtl/ex_mem_pipe_stage.sv
// ex_mem_pipe_stage
//   EX/MEM pipeline register with valid/ready handshake and a 2-entry skid
//   buffer (main + skid), so a drop of out_ready costs no throughput.
//   Ports:
//     clk, rst_n : clock, synchronous active-low reset
//     flush      : drops all held beats and the same-cycle input
//     bus        : ex_mem_pipe_stage_if.slave (input beat / output beat)
//     stall_cnt  : saturating count of cycles with out_valid & !out_ready
//   in_ready is a register (never combinational from out_ready); control
//   strobes are squashed to 0 whenever no beat is presented.
module ex_mem_pipe_stage #(
  parameter int RES_W   = 64,
  parameter int RT_W    = 32,
  parameter int DEST_W  = 5,
  parameter int WB_W    = 4,
  parameter int MEM_W   = 3,
  parameter int FLOAT_W = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  ex_mem_pipe_stage_if.slave bus,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [WB_W-1:0]    wb;
    logic [MEM_W-1:0]   mem;
    logic [FLOAT_W-1:0] flt;
    logic [RES_W-1:0]   res;
    logic [RT_W-1:0]    rt;
    logic [DEST_W-1:0]  dest;
    logic               rd;
    logic               wr;
    logic               rw;
  } beat_t;

  // State bits are {main_valid, skid_valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b10,
    SKID  = 2'b11
  } state_t;

  state_t           st_q;
  beat_t            main_q, skid_q, in_beat;
  logic             rdy_q;
  logic [CNT_W-1:0] cnt_q;
  logic             main_vld, accept, pop;

  assign in_beat = '{
    wb:   bus.wb_in,
    mem:  bus.mem_in,
    flt:  bus.float_in,
    res:  bus.alu_res_in,
    rt:   bus.rt_data_in,
    dest: bus.dest_in,
    rd:   bus.alu_mem_read_in,
    wr:   bus.alu_mem_write_in,
    rw:   bus.alu_RegWrite_in
  };

  assign main_vld = st_q[1];
  assign accept   = bus.in_valid & rdy_q;
  assign pop      = main_vld & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      rdy_q  <= 1'b0;  // ready rises on the first edge out of reset
      cnt_q  <= '0;
    end else begin
      if (main_vld && !bus.out_ready && !flush && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;

      if (flush) begin
        st_q  <= EMPTY;
        rdy_q <= 1'b1;
      end else begin
        rdy_q <= 1'b1;
        case (st_q)
          EMPTY: begin
            if (accept) begin
              main_q <= in_beat;
              st_q   <= FULL;
            end
          end
          FULL: begin
            if (accept && pop) begin
              main_q <= in_beat;
            end else if (accept) begin
              // Beat arrived as the consumer stalled: park it in skid.
              skid_q <= in_beat;
              st_q   <= SKID;
              rdy_q  <= 1'b0;
            end else if (pop) begin
              st_q <= EMPTY;
            end
          end
          SKID: begin
            if (pop) begin
              main_q <= skid_q;
              st_q   <= FULL;
            end else begin
              rdy_q <= 1'b0;
            end
          end
          default: st_q <= EMPTY;
        endcase
      end
    end
  end

  assign bus.in_ready          = rdy_q;
  assign bus.out_valid         = main_vld;
  assign bus.alu_res_out       = main_q.res;
  assign bus.rt_data_out       = main_q.rt;
  assign bus.dest_out          = main_q.dest;
  assign bus.float_out         = main_q.flt;
  // Bubbles must not trigger memory or register-file side effects.
  assign bus.wb_out            = main_vld ? main_q.wb  : '0;
  assign bus.mem_out           = main_vld ? main_q.mem : '0;
  assign bus.alu_mem_read_out  = main_vld & main_q.rd;
  assign bus.alu_mem_write_out = main_vld & main_q.wr;
  assign bus.alu_RegWrite_out  = main_vld & main_q.rw;
  assign stall_cnt             = cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
module tb_ex_mem_pipe_stage;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n, flush;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  ex_mem_pipe_stage_if bus ();

  ex_mem_pipe_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [3:0]  wb;
    logic [2:0]  mem;
    logic [1:0]  flt;
    logic [63:0] res;
    logic [31:0] rt;
    logic [4:0]  dest;
    logic        rd, wr, rw;
  } mbeat_t;

  typedef struct {
    logic        rst_n, flush, iv, ordy;
    logic [63:0] res;
    logic [4:0]  dest;
    logic        wr;
    logic        eov, eir, chkd;
    logic [63:0] eres;
    logic [4:0]  edest;
    logic        ewr;
    int          ecnt;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model: an ordered queue of held beats (at most two).
  mbeat_t q[$];
  logic   mrdy;
  int     mcnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic ordy,
                       input logic [63:0] res, input logic [4:0] dest, input logic wr);
    rst_n                = r;
    flush                = f;
    bus.in_valid         = iv;
    bus.out_ready        = ordy;
    bus.alu_res_in       = res;
    bus.rt_data_in       = res[31:0] ^ 32'h5A5A_0000;
    bus.dest_in          = dest;
    bus.wb_in            = res[3:0];
    bus.mem_in           = res[2:0];
    bus.float_in         = res[1:0];
    bus.alu_mem_read_in  = res[0];
    bus.alu_mem_write_in = wr;
    bus.alu_RegWrite_in  = res[2];
  endtask

  function automatic mbeat_t cur_beat();
    mbeat_t b;
    b.wb = bus.wb_in; b.mem = bus.mem_in; b.flt = bus.float_in;
    b.res = bus.alu_res_in; b.rt = bus.rt_data_in; b.dest = bus.dest_in;
    b.rd = bus.alu_mem_read_in; b.wr = bus.alu_mem_write_in; b.rw = bus.alu_RegWrite_in;
    return b;
  endfunction

  task automatic model_edge();
    bit acc, pp;
    if (!rst_n) begin
      q.delete(); mrdy = 1'b0; mcnt = 0;
    end else if (flush) begin
      q.delete(); mrdy = 1'b1;
    end else begin
      acc = bus.in_valid && mrdy;
      pp  = (q.size() > 0) && bus.out_ready;
      if (q.size() > 0 && !bus.out_ready && mcnt < CMAX) mcnt++;
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(cur_beat());
      mrdy = (q.size() < 2);
    end
  endtask

  task automatic model_check();
    logic ov;
    ov = (q.size() > 0);
    chk("m_out_valid", 64'(bus.out_valid), 64'(ov));
    chk("m_in_ready", 64'(bus.in_ready), 64'(mrdy));
    chk("m_stall_cnt", 64'(stall_cnt), 64'(mcnt));
    if (ov) begin
      chk("m_res", bus.alu_res_out, q[0].res);
      chk("m_rt", 64'(bus.rt_data_out), 64'(q[0].rt));
      chk("m_dest", 64'(bus.dest_out), 64'(q[0].dest));
      chk("m_wb", 64'(bus.wb_out), 64'(q[0].wb));
      chk("m_mem", 64'(bus.mem_out), 64'(q[0].mem));
      chk("m_float", 64'(bus.float_out), 64'(q[0].flt));
      chk("m_strobes", 64'({bus.alu_mem_read_out, bus.alu_mem_write_out, bus.alu_RegWrite_out}),
          64'({q[0].rd, q[0].wr, q[0].rw}));
    end else begin
      chk("m_squash", 64'({bus.wb_out, bus.mem_out, bus.alu_mem_read_out,
                           bus.alu_mem_write_out, bus.alu_RegWrite_out}), 64'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  function automatic vec_t mk(logic r, logic f, logic iv, logic ordy, logic [63:0] res,
                              logic [4:0] dest, logic wr, logic eov, logic eir, logic chkd,
                              logic [63:0] eres, logic [4:0] edest, logic ewr, int ecnt);
    vec_t v;
    v.rst_n = r; v.flush = f; v.iv = iv; v.ordy = ordy; v.res = res; v.dest = dest; v.wr = wr;
    v.eov = eov; v.eir = eir; v.chkd = chkd; v.eres = eres; v.edest = edest; v.ewr = ewr;
    v.ecnt = ecnt;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    // rst flush iv ordy res dest wr | ov ir chkd res dest wr cnt
    tbl[0]  = mk(0,0,1,0,64'hDEAD,0,1,   0,0,1,0,0,0,0);   // reset, input ignored
    tbl[1]  = mk(0,0,1,0,64'hDEAD,0,1,   0,0,1,0,0,0,0);
    tbl[2]  = mk(1,0,0,1,0,0,0,          0,1,1,0,0,0,0);   // ready after release
    tbl[3]  = mk(1,0,1,1,1,1,0,          1,1,1,1,1,0,0);   // streaming
    tbl[4]  = mk(1,0,1,1,2,2,0,          1,1,1,2,2,0,0);
    tbl[5]  = mk(1,0,1,1,3,3,0,          1,1,1,3,3,0,0);
    tbl[6]  = mk(1,0,1,1,10,10,1,        1,1,1,10,10,1,0); // A presented
    tbl[7]  = mk(1,0,1,0,11,11,0,        1,0,1,10,10,1,1); // B into skid
    tbl[8]  = mk(1,0,1,0,12,12,1,        1,0,1,10,10,1,2); // C held off
    tbl[9]  = mk(1,0,1,0,12,12,1,        1,0,1,10,10,1,3);
    tbl[10] = mk(1,0,1,1,12,12,1,        1,1,1,11,11,0,3); // B out
    tbl[11] = mk(1,0,1,1,12,12,1,        1,1,1,12,12,1,3); // C out
    tbl[12] = mk(1,0,0,1,0,0,0,          0,1,0,0,0,0,3);   // squash after pop
    tbl[13] = mk(1,0,1,0,20,20,1,        1,1,1,20,20,1,3);
    tbl[14] = mk(1,0,1,0,21,21,1,        1,0,1,20,20,1,4); // SKID
    tbl[15] = mk(1,1,1,0,7,7,1,          0,1,0,0,0,0,4);   // flush in SKID
    tbl[16] = mk(1,0,0,1,0,0,0,          0,1,0,0,0,0,4);

    drive(0, 0, 0, 0, 0, 0, 0);
    mrdy = 1'b0; mcnt = 0;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst_n, tbl[i].flush, tbl[i].iv, tbl[i].ordy, tbl[i].res, tbl[i].dest, tbl[i].wr);
      tick();
      chk($sformatf("v%0d_out_valid", i), 64'(bus.out_valid), 64'(tbl[i].eov));
      chk($sformatf("v%0d_in_ready", i), 64'(bus.in_ready), 64'(tbl[i].eir));
      chk($sformatf("v%0d_mem_write", i), 64'(bus.alu_mem_write_out), 64'(tbl[i].ewr));
      chk($sformatf("v%0d_stall_cnt", i), 64'(stall_cnt), 64'(tbl[i].ecnt));
      if (tbl[i].chkd) begin
        chk($sformatf("v%0d_res", i), bus.alu_res_out, tbl[i].eres);
        chk($sformatf("v%0d_dest", i), 64'(bus.dest_out), 64'(tbl[i].edest));
      end
    end

    // Saturation: hold a beat under back-pressure for 20 cycles.
    drive(1, 0, 1, 0, 30, 30, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt", 64'(stall_cnt), 64'(CMAX));
    drive(1, 1, 0, 0, 0, 0, 0);
    tick();
    chk("sat_after_flush", 64'(stall_cnt), 64'(CMAX));
    chk("sat_flush_valid", 64'(bus.out_valid), 64'd0);

    // Reset mid-stream in SKID, with flush also asserted.
    drive(1, 0, 1, 0, 40, 1, 1);
    tick();
    drive(1, 0, 1, 0, 41, 2, 1);
    tick();
    chk("skid_in_ready", 64'(bus.in_ready), 64'd0);
    drive(0, 1, 1, 0, 42, 3, 1);
    tick();
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_res", bus.alu_res_out, 64'd0);
    chk("rst_rt", 64'(bus.rt_data_out), 64'd0);
    chk("rst_dest_float", 64'({bus.dest_out, bus.float_out}), 64'd0);
    chk("rst_cnt", 64'(stall_cnt), 64'd0);
    drive(1, 0, 0, 1, 0, 0, 0);
    tick();
    chk("rst_release_ready", 64'(bus.in_ready), 64'd1);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            {$urandom, $urandom}, 5'($urandom), 1'($urandom));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
